// File: rtl/tokenizer_pkg.sv
// tokenizer_pkg: token codes, ASCII constants and keyword matching helper for keyword_tokenizer.
package tokenizer_pkg;
  typedef enum logic [1:0] {TOK_OTHER = 2'b00, TOK_BEGIN = 2'b01, TOK_END = 2'b10} tok_type_t;
  typedef enum logic {S_IDLE, S_WORD} state_t;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam int KW_BEGIN_LEN = 5;
  localparam int KW_END_LEN = 3;
  // Keywords are left-aligned in 5 bytes so character i always sits at kw[39-8*i -: 8].
  localparam logic [39:0] KW_BEGIN_STR = "begin";
  localparam logic [39:0] KW_END_STR = {"end", 16'h0000};
  function automatic logic kw_hit(input logic [39:0] kw, input int kw_len, input logic [7:0] c,
                                  input int pos);
    logic h;
    h = 1'b0;
    for (int i = 0; i < 5; i++)
      if (i == pos && i < kw_len) h = ((c | 8'h20) == kw[39-8*i -: 8]);
    return h;
  endfunction
endpackage

// File: rtl/tok_fifo.sv
// tok_fifo: synchronous show-ahead FIFO with async active-high reset; reads zero while empty.
module tok_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_q];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wr_data_i;
endmodule

// File: rtl/keyword_tokenizer.sv
// keyword_tokenizer: splits a byte stream into words, classifies BEGIN/END/OTHER, queues tokens.
// Define TOK_WS_DELIM_EN to make tab, LF and CR delimiters as well as space.
module keyword_tokenizer
  import tokenizer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             flush,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [1:0]       tok_type,
  output logic [LEN_W-1:0] tok_len,
  output logic             overflow
);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic b_ok_q, b_ok_d, e_ok_q, e_ok_d, ovf_q, ovf_d;
  logic full, empty, delim, acc, grow, idle, sat, active, push;
  int pos;
  tok_type_t ty;
  logic [LEN_W+1:0] rd_data;
`ifdef TOK_WS_DELIM_EN
  assign delim = in_char inside {ASCII_SPACE, ASCII_TAB, ASCII_LF, ASCII_CR};
`else
  assign delim = in_char == ASCII_SPACE;
`endif
  assign in_ready = !reset && !full;
  assign acc = in_valid && in_ready;
  assign grow = acc && !delim;
  assign idle = state_q == S_IDLE;
  assign tok_valid = !empty;
  assign tok_type = rd_data[LEN_W +: 2];
  assign tok_len = rd_data[LEN_W-1:0];
  assign overflow = ovf_q;
  // The byte is folded into the word first; a delimiter or flush then closes it on the same edge.
  always_comb begin
    sat = grow && !idle && len_q == LEN_MAX;
    pos = idle ? 0 : int'(len_q);
    len_d = !grow ? len_q : idle ? LEN_ONE : sat ? len_q : len_q + LEN_ONE;
    b_ok_d = grow ? (idle || b_ok_q) && !sat && kw_hit(KW_BEGIN_STR, KW_BEGIN_LEN, in_char, pos) : b_ok_q;
    e_ok_d = grow ? (idle || e_ok_q) && !sat && kw_hit(KW_END_STR, KW_END_LEN, in_char, pos) : e_ok_q;
    ovf_d = ovf_q || sat;
    active = grow || !idle;
    push = active && ((acc && delim) || flush) && !full;
    state_d = push ? S_IDLE : active ? S_WORD : S_IDLE;
    ty = (b_ok_d && int'(len_d) == KW_BEGIN_LEN) ? TOK_BEGIN :
         (e_ok_d && int'(len_d) == KW_END_LEN) ? TOK_END : TOK_OTHER;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      len_q <= '0;
      b_ok_q <= 1'b0;
      e_ok_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      b_ok_q <= b_ok_d;
      e_ok_q <= e_ok_d;
      ovf_q <= ovf_d;
    end
  tok_fifo #(.WIDTH(LEN_W + 2), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(push),
    .pop_i(tok_ready),
    .wr_data_i({ty, len_d}),
    .rd_data_o(rd_data),
    .full_o(full),
    .empty_o(empty)
  );
endmodule
